// File: rtl/wnd_pkg.sv
// Shared definitions for the windowed register file and its window-pointer control:
// the window-control encodings and the default geometry.
package wnd_pkg;

  localparam logic [1:0] WND_HOLD    = 2'b00;
  localparam logic [1:0] WND_SAVE    = 2'b01;
  localparam logic [1:0] WND_RESTORE = 2'b10;
  localparam logic [1:0] WND_SET     = 2'b11;

  localparam int WND_WIDTH = 8;
  localparam int WND_AW    = 2;
  localparam int WND_NWIN  = 4;

endpackage

// File: rtl/wnd_ptr.sv
// Current-window pointer with optional occupancy tracking and sticky traps.
// Build option REG_WND_TRAP_EN: occupancy counter plus overflow/underflow flags.
module wnd_ptr
  import wnd_pkg::*;
#(
  parameter  int NWIN = WND_NWIN,
  localparam int WW   = $clog2(NWIN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_wnd_i,
  input  logic [1:0]    wnd_ctrl_i,
  input  logic [WW-1:0] wnd_in_i,
  input  logic          trap_clr_i,
  output logic [WW-1:0] cwp_o,
  output logic          wnd_ovf_o,
  output logic          wnd_unf_o
);

  logic [WW-1:0] cwp_q, cwp_d;

`ifdef REG_WND_TRAP_EN
  localparam int OW = $clog2(NWIN + 1);
  localparam logic [OW-1:0] OCC_MAX = OW'(NWIN);
  localparam logic [OW-1:0] OCC_MIN = OW'(1);

  logic [OW-1:0] occ_q, occ_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  always_comb begin
    cwp_d = cwp_q;
    occ_d = occ_q;
    // A trap raised this cycle overrides a simultaneous clear.
    ovf_d = ovf_q & ~trap_clr_i;
    unf_d = unf_q & ~trap_clr_i;
    if (ld_wnd_i) begin
      case (wnd_ctrl_i)
        WND_SAVE: begin
          if (occ_q == OCC_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cwp_d = cwp_q + WW'(1);
            occ_d = occ_q + OW'(1);
          end
        end
        WND_RESTORE: begin
          if (occ_q == OCC_MIN) begin
            unf_d = 1'b1;
          end else begin
            cwp_d = cwp_q - WW'(1);
            occ_d = occ_q - OW'(1);
          end
        end
        WND_SET: begin
          cwp_d = wnd_in_i;
          occ_d = OCC_MIN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cwp_q <= '0;
      occ_q <= OCC_MIN;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cwp_q <= cwp_d;
      occ_q <= occ_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign wnd_ovf_o = ovf_q;
  assign wnd_unf_o = unf_q;
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr_i;

  always_comb begin
    cwp_d = cwp_q;
    if (ld_wnd_i) begin
      case (wnd_ctrl_i)
        WND_SAVE:    cwp_d = cwp_q + WW'(1);
        WND_RESTORE: cwp_d = cwp_q - WW'(1);
        WND_SET:     cwp_d = wnd_in_i;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cwp_q <= '0;
    else     cwp_q <= cwp_d;
  end

  assign wnd_ovf_o = 1'b0;
  assign wnd_unf_o = 1'b0;
`endif

  assign cwp_o = cwp_q;

endmodule

// File: rtl/reg_window_file.sv
// Windowed register file: NWIN banks of 2**AW words, addressed through the current window.
// Build option REG_WND_TRAP_EN enables occupancy traps in the window pointer.
module reg_window_file
  import wnd_pkg::*;
#(
  parameter  int WIDTH = WND_WIDTH,
  parameter  int AW    = WND_AW,
  parameter  int NWIN  = WND_NWIN,
  localparam int WW    = $clog2(NWIN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regWrite,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr1,
  input  logic [AW-1:0]    rdAddr2,
  output logic [WIDTH-1:0] rdData1,
  output logic [WIDTH-1:0] rdData2,
  input  logic             ldWnd,
  input  logic [1:0]       wndCtrl,
  input  logic [WW-1:0]    wndIn,
  input  logic             trapClr,
  output logic [WW-1:0]    cwp,
  output logic             wndOvf,
  output logic             wndUnf
);

  localparam int IW    = WW + AW;
  localparam int DEPTH = NWIN * (2 ** AW);

  logic [WIDTH-1:0] word_q [DEPTH];
  logic [IW-1:0]    wr_idx;

  wnd_ptr #(.NWIN(NWIN)) u_wnd_ptr (
    .clk        (clk),
    .rst        (rst),
    .ld_wnd_i   (ldWnd),
    .wnd_ctrl_i (wndCtrl),
    .wnd_in_i   (wndIn),
    .trap_clr_i (trapClr),
    .cwp_o      (cwp),
    .wnd_ovf_o  (wndOvf),
    .wnd_unf_o  (wndUnf)
  );

  // cwp is the pre-edge window, so a write alongside a window change lands in the old window.
  assign wr_idx = {cwp, wrAddr};

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge clk) begin
      if (rst) begin
        word_q[gi] <= '0;
      end else if (regWrite && (wr_idx == IW'(gi))) begin
        word_q[gi] <= wrData;
      end
    end
  end

  assign rdData1 = word_q[{cwp, rdAddr1}];
  assign rdData2 = word_q[{cwp, rdAddr2}];

endmodule

// File: tb/tb_reg_window_file.sv
// Directed self-checking bench for reg_window_file; expectations follow the build option REG_WND_TRAP_EN.
module tb_reg_window_file;
  import wnd_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       regWrite;
  logic [1:0] wrAddr;
  logic [7:0] wrData;
  logic [1:0] rdAddr1, rdAddr2;
  logic [7:0] rdData1, rdData2;
  logic       ldWnd;
  logic [1:0] wndCtrl;
  logic [1:0] wndIn;
  logic       trapClr;
  logic [1:0] cwp;
  logic       wndOvf, wndUnf;

  int n_checks = 0;
  int n_errors = 0;

`ifdef REG_WND_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_window_file dut (
    .clk(clk), .rst(rst), .regWrite(regWrite), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdData1(rdData1), .rdData2(rdData2),
    .ldWnd(ldWnd), .wndCtrl(wndCtrl), .wndIn(wndIn), .trapClr(trapClr),
    .cwp(cwp), .wndOvf(wndOvf), .wndUnf(wndUnf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One clock edge, then settle 1 time unit past it before anything is sampled or driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWrite = 1'b0;
    ldWnd    = 1'b0;
    wndCtrl  = WND_HOLD;
    trapClr  = 1'b0;
  endtask

  task automatic wnd_op(input logic [1:0] op);
    ldWnd = 1'b1; wndCtrl = op;
    step();
    idle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    regWrite = 1'b1; wrAddr = a; wrData = d;
    step();
    idle();
  endtask

  initial begin
    rst = 1'b1; idle();
    wrAddr = '0; wrData = '0; rdAddr1 = '0; rdAddr2 = '0; wndIn = '0;
    step(); step();
    rst = 1'b0;
    check("reset rdData1", rdData1, 8'h00);
    check("reset rdData2", rdData2, 8'h00);
    check("reset cwp", cwp, 2'd0);
    check("reset wndOvf", wndOvf, 1'b0);
    check("reset wndUnf", wndUnf, 1'b0);

    // Basic write/read with no bypass
    rdAddr1 = 2'd1;
    regWrite = 1'b1; wrAddr = 2'd1; wrData = 8'h5A;
    #1;
    check("no bypass before edge", rdData1, 8'h00);
    step(); idle();
    check("w0 r1 after write", rdData1, 8'h5A);
    check("cwp after write", cwp, 2'd0);

    // Window separation across save/restore
    rdAddr2 = 2'd2;
    wr(2'd2, 8'h11);
    wnd_op(WND_SAVE);
    check("cwp after save", cwp, 2'd1);
    check("w1 r2 fresh", rdData2, 8'h00);
    wr(2'd2, 8'h22);
    wnd_op(WND_RESTORE);
    check("w0 r2 after restore", rdData2, 8'h11);
    check("cwp after restore", cwp, 2'd0);
    wnd_op(WND_SAVE);
    check("w1 r2 after save", rdData2, 8'h22);
    wnd_op(WND_RESTORE);

    // Write coinciding with a save lands in the old window
    rdAddr1 = 2'd0;
    regWrite = 1'b1; wrAddr = 2'd0; wrData = 8'h33;
    ldWnd = 1'b1; wndCtrl = WND_SAVE;
    step(); idle();
    check("cwp after write+save", cwp, 2'd1);
    check("w1 r0 untouched", rdData1, 8'h00);
    wnd_op(WND_RESTORE);
    check("w0 r0 got write", rdData1, 8'h33);

    // Set
    wndIn = 2'd2;
    wnd_op(WND_SET);
    check("cwp after set", cwp, 2'd2);
    check("w2 r0", rdData1, 8'h00);

    // Overflow behaviour from reset
    rst = 1'b1; step(); rst = 1'b0;
    wnd_op(WND_SAVE); check("save1 cwp", cwp, 2'd1);
    wnd_op(WND_SAVE); check("save2 cwp", cwp, 2'd2);
    wnd_op(WND_SAVE); check("save3 cwp", cwp, 2'd3);
    check("save3 wndOvf", wndOvf, 1'b0);
    wnd_op(WND_SAVE);
    check("save4 cwp", cwp, TRAP ? 2'd3 : 2'd0);
    check("save4 wndOvf", wndOvf, TRAP ? 1'b1 : 1'b0);
    check("save4 wndUnf", wndUnf, 1'b0);
    if (!TRAP) begin
      // Bring the pointer back to 3 so the next save is the same boundary case
      wnd_op(WND_RESTORE);
      check("wrap restore cwp", cwp, 2'd3);
    end
    trapClr = 1'b1;
    wnd_op(WND_SAVE);
    check("clr+ovf wndOvf", wndOvf, TRAP ? 1'b1 : 1'b0);
    check("clr+ovf cwp", cwp, TRAP ? 2'd3 : 2'd0);
    trapClr = 1'b1; step(); idle();
    check("trapClr wndOvf", wndOvf, 1'b0);

    // Underflow from reset
    rst = 1'b1; step(); rst = 1'b0;
    wnd_op(WND_RESTORE);
    check("restore@reset cwp", cwp, TRAP ? 2'd0 : 2'd3);
    check("restore@reset wndUnf", wndUnf, TRAP ? 1'b1 : 1'b0);
    check("restore@reset wndOvf", wndOvf, 1'b0);

    // Reset mid-operation discards the pending write and window change
    wndIn = 2'd0;
    wnd_op(WND_SET);
    rdAddr1 = 2'd1;
    wr(2'd1, 8'h44);
    check("w0 r1 pre-reset", rdData1, 8'h44);
    rst = 1'b1; regWrite = 1'b1; wrAddr = 2'd1; wrData = 8'h99;
    ldWnd = 1'b1; wndCtrl = WND_SAVE;
    step(); rst = 1'b0; idle();
    check("mid reset rdData1", rdData1, 8'h00);
    check("mid reset cwp", cwp, 2'd0);
    check("mid reset wndOvf", wndOvf, 1'b0);
    check("mid reset wndUnf", wndUnf, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
